// File: rtl/rename_map_table.sv
// Register rename stage: architectural-to-physical map with a ring of branch checkpoints.
// It allocates destination tags from the free list and restores the map and free-list pointer on a mispredict.
module rename_map_table #(
  parameter int ARCH_REGS = 32,
  parameter int PREG_W    = 8,
  parameter int NUM_CKPT  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [$clog2(ARCH_REGS)-1:0] rs1,
  input  logic [$clog2(ARCH_REGS)-1:0] rs2,
  input  logic [$clog2(ARCH_REGS)-1:0] rd,
  input  logic                         rd_wen,
  input  logic                         is_branch,
  input  logic [PREG_W-1:0]            fl_preg,
  input  logic                         fl_empty,
  input  logic [PREG_W-1:0]            fl_ptr,
  output logic                         fl_read_en,
  output logic                         fl_mispredict,
  output logic [PREG_W-1:0]            fl_re_ptr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PREG_W-1:0]            out_prs1,
  output logic [PREG_W-1:0]            out_prs2,
  output logic [PREG_W-1:0]            out_prd,
  output logic [PREG_W-1:0]            out_old_prd,
  output logic [$clog2(NUM_CKPT)-1:0]  out_ckpt_id,
  output logic                         out_is_branch,
  input  logic                         mispredict,
  input  logic                         resolve_valid,
  input  logic [$clog2(NUM_CKPT)-1:0]  resolve_ckpt_id
);

  localparam int AW       = $clog2(ARCH_REGS);
  localparam int CW       = $clog2(NUM_CKPT);
  localparam int NW       = $clog2(NUM_CKPT + 1);
  localparam int PTR_BITS = 7;

  // Free-list read pointer arithmetic wraps at 128 entries.
  function automatic logic [PREG_W-1:0] wrap_ptr(input logic [PREG_W-1:0] p, input logic inc);
    logic [PREG_W-1:0] sum;
    sum = p + PREG_W'(inc);
    return sum & PREG_W'((1 << PTR_BITS) - 1);
  endfunction

  function automatic logic [CW-1:0] ring_inc(input logic [CW-1:0] idx);
    return idx + CW'(1);
  endfunction

  logic [PREG_W-1:0] map_q    [ARCH_REGS];
  logic [PREG_W-1:0] ckpt_map [NUM_CKPT][ARCH_REGS];
  logic [PREG_W-1:0] ckpt_ptr [NUM_CKPT];
  logic [NUM_CKPT-1:0] resolved_q;
  logic [CW-1:0] head_q, tail_q;
  logic [NW-1:0] count_q;

  logic              vld_p1, br_p1, fl_mp_p1;
  logic [PREG_W-1:0] prs1_p1, prs2_p1, prd_p1, old_prd_p1, re_ptr_p1;
  logic [CW-1:0]     ckpt_id_p1;

  logic          alloc, ring_full, fire, br_fire, retire, id_live;
  logic [CW-1:0] mp_tail, mp_span, id_off;
  logic [NW-1:0] mp_count;

  always_comb begin
    alloc      = rd_wen && (rd != '0);
    ring_full  = (count_q == NW'(NUM_CKPT));
    in_ready   = (!vld_p1 || out_ready) && !(alloc && fl_empty) &&
                 !(is_branch && ring_full) && !mispredict;
    fire       = in_valid && in_ready;
    fl_read_en = fire && alloc;
    br_fire    = fire && is_branch;
    retire     = !mispredict && (count_q != '0) && resolved_q[head_q];
    mp_tail    = ring_inc(resolve_ckpt_id);
    mp_span    = mp_tail - head_q;
    // Restored tail landing on head means every slot survived: the ring is full.
    mp_count   = (mp_span == '0) ? NW'(NUM_CKPT) : NW'(mp_span);
    id_off     = resolve_ckpt_id - head_q;
    id_live    = (NW'(id_off) < count_q);
  end

  // Stage p0 -> p1: map update, checkpoint ring control and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PREG_W'(i);
      resolved_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      vld_p1     <= 1'b0;
      br_p1      <= 1'b0;
      fl_mp_p1   <= 1'b0;
      re_ptr_p1  <= '0;
      prs1_p1    <= '0;
      prs2_p1    <= '0;
      prd_p1     <= '0;
      old_prd_p1 <= '0;
      ckpt_id_p1 <= '0;
    end else begin
      fl_mp_p1 <= mispredict;
      if (mispredict) begin
        for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= ckpt_map[resolve_ckpt_id][i];
        re_ptr_p1 <= ckpt_ptr[resolve_ckpt_id];
        tail_q    <= mp_tail;
        count_q   <= mp_count;
        vld_p1    <= 1'b0;
      end else begin
        if (fl_read_en) map_q[rd] <= fl_preg;
        if (resolve_valid) resolved_q[resolve_ckpt_id] <= 1'b1;
        if (br_fire) begin
          resolved_q[tail_q] <= 1'b0;
          tail_q             <= ring_inc(tail_q);
        end
        if (retire) head_q <= ring_inc(head_q);
        count_q <= count_q + NW'(br_fire) - NW'(retire);
        if (fire) begin
          vld_p1     <= 1'b1;
          prs1_p1    <= map_q[rs1];
          prs2_p1    <= map_q[rs2];
          prd_p1     <= alloc ? fl_preg : '0;
          old_prd_p1 <= alloc ? map_q[rd] : '0;
          br_p1      <= is_branch;
          ckpt_id_p1 <= is_branch ? tail_q : '0;
        end else if (out_ready) begin
          vld_p1 <= 1'b0;
        end
      end
    end
  end

  // Checkpoint snapshot includes the branch's own rd update (JAL/JALR link register).
  always_ff @(posedge clk) begin
    if (br_fire) begin
      for (int i = 0; i < ARCH_REGS; i++)
        ckpt_map[tail_q][i] <= (alloc && (rd == AW'(i))) ? fl_preg : map_q[i];
      ckpt_ptr[tail_q] <= wrap_ptr(fl_ptr, alloc);
    end
  end

  mp_slot_live: assert property (@(posedge clk) disable iff (!reset) mispredict |-> id_live);

  assign out_valid     = vld_p1;
  assign out_prs1      = prs1_p1;
  assign out_prs2      = prs2_p1;
  assign out_prd       = prd_p1;
  assign out_old_prd   = old_prd_p1;
  assign out_ckpt_id   = ckpt_id_p1;
  assign out_is_branch = br_p1;
  assign fl_mispredict = fl_mp_p1;
  assign fl_re_ptr     = re_ptr_p1;

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: renaming, stalls, checkpoint ring and mispredict recovery.
module tb_rename_map_table;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready;
  logic [4:0] rs1, rs2, rd;
  logic       rd_wen, is_branch;
  logic [7:0] fl_preg, fl_ptr, fl_re_ptr;
  logic       fl_empty, fl_read_en, fl_mispredict;
  logic       out_valid, out_ready, out_is_branch;
  logic [7:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic [1:0] out_ckpt_id, resolve_ckpt_id;
  logic       mispredict, resolve_valid;

  int checks = 0;
  int errors = 0;

  rename_map_table #(.ARCH_REGS(32), .PREG_W(8), .NUM_CKPT(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_wen(rd_wen), .is_branch(is_branch),
    .fl_preg(fl_preg), .fl_empty(fl_empty), .fl_ptr(fl_ptr),
    .fl_read_en(fl_read_en), .fl_mispredict(fl_mispredict), .fl_re_ptr(fl_re_ptr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prs1(out_prs1), .out_prs2(out_prs2), .out_prd(out_prd), .out_old_prd(out_old_prd),
    .out_ckpt_id(out_ckpt_id), .out_is_branch(out_is_branch),
    .mispredict(mispredict), .resolve_valid(resolve_valid), .resolve_ckpt_id(resolve_ckpt_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d, input logic wen, input logic br,
                       input logic [7:0] preg);
    in_valid  = v;
    rs1       = r1;
    rs2       = r2;
    rd        = d;
    rd_wen    = wen;
    is_branch = br;
    fl_preg   = preg;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0);
    fl_empty = 1'b0; fl_ptr = 8'd0; out_ready = 1'b1;
    mispredict = 1'b0; resolve_valid = 1'b0; resolve_ckpt_id = 2'd0;
    tick(); tick();

    // Reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_prd", out_prd, 0);
    chk("rst_fl_mispredict", fl_mispredict, 0);
    chk("rst_fl_re_ptr", fl_re_ptr, 0);
    chk("rst_fl_read_en", fl_read_en, 0);
    reset = 1'b1;
    tick();

    // Basic rename, then a back-to-back dependent instruction on the same rd
    drive(1'b1, 5'd3, 5'd0, 5'd5, 1'b1, 1'b0, 8'd40);
    #1;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_fl_read_en", fl_read_en, 1);
    tick();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_prs1", out_prs1, 3);
    chk("t1_prs2", out_prs2, 0);
    chk("t1_prd", out_prd, 40);
    chk("t1_old_prd", out_old_prd, 5);
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 8'd41);
    #1;
    chk("t2_fl_read_en", fl_read_en, 1);
    tick();
    chk("t2_prs1", out_prs1, 40);
    chk("t2_old_prd", out_old_prd, 40);
    chk("t2_prd", out_prd, 41);

    // rd = x0 never allocates
    drive(1'b1, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 8'd99);
    #1;
    chk("t3_fl_read_en", fl_read_en, 0);
    tick();
    chk("t3_prd", out_prd, 0);
    chk("t3_old_prd", out_old_prd, 0);
    chk("t3_prs1_x0", out_prs1, 0);
    chk("t3_prs2", out_prs2, 41);

    // Free list empty blocks only allocating instructions
    fl_empty = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 8'd44);
    #1;
    chk("t4_in_ready_empty", in_ready, 0);
    tick();
    chk("t4_out_valid_drop", out_valid, 0);
    rd_wen = 1'b0;
    #1;
    chk("t4_in_ready_noalloc", in_ready, 1);
    chk("t4_fl_read_en", fl_read_en, 0);
    tick();
    chk("t4_out_valid", out_valid, 1);
    chk("t4_prd", out_prd, 0);
    fl_empty = 1'b0;

    // Downstream backpressure for three cycles
    drive(1'b1, 5'd6, 5'd0, 5'd8, 1'b1, 1'b0, 8'd42);
    tick();
    chk("t5_prd", out_prd, 42);
    out_ready = 1'b0;
    drive(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b0, 8'd43);
    #1;
    chk("t5_in_ready_stall", in_ready, 0);
    chk("t5_fl_read_en_stall", fl_read_en, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_prd", out_prd, 42);
      chk("t5_hold_read_en", fl_read_en, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("t5_in_ready_release", in_ready, 1);
    tick();
    chk("t5_next_prd", out_prd, 43);
    chk("t5_next_prs1", out_prs1, 42);
    chk("t5_next_old_prd", out_old_prd, 9);
    in_valid = 1'b0;
    tick();
    chk("t5_drain", out_valid, 0);

    // Asynchronous reset mid-stream
    reset = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_prd", out_prd, 0);
    tick();
    reset = 1'b1;
    #1;
    chk("ar_fl_read_en", fl_read_en, 0);
    tick();

    // Branch checkpoint, younger rename, mispredict restore
    fl_ptr = 8'd10;
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b1, 8'd0);
    tick();
    chk("t6_br_prs1_reset_map", out_prs1, 5);
    chk("t6_br_is_branch", out_is_branch, 1);
    chk("t6_br_ckpt_id", out_ckpt_id, 0);
    fl_ptr = 8'd11;
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 8'd50);
    tick();
    chk("t6_x7_prd", out_prd, 50);
    chk("t6_x7_old_prd", out_old_prd, 7);
    in_valid = 1'b0;
    mispredict = 1'b1;
    resolve_ckpt_id = 2'd0;
    #1;
    chk("t6_in_ready_mp", in_ready, 0);
    tick();
    mispredict = 1'b0;
    chk("t6_fl_mispredict", fl_mispredict, 1);
    chk("t6_fl_re_ptr", fl_re_ptr, 10);
    chk("t6_squash", out_valid, 0);
    drive(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 8'd0);
    tick();
    chk("t6_mp_pulse_end", fl_mispredict, 0);
    chk("t6_x7_restored", out_prs1, 7);
    in_valid = 1'b0;
    tick();

    // Checkpoint ring: fill, stall, in-order retire, reuse of slot 0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 8'd0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t7_fill_ready", in_ready, 1);
      tick();
      chk("t7_fill_ckpt_id", out_ckpt_id, k);
    end
    #1;
    chk("t7_full_stall", in_ready, 0);
    tick();
    chk("t7_stall_out_valid", out_valid, 0);
    resolve_valid = 1'b1;
    resolve_ckpt_id = 2'd1;
    tick();
    resolve_ckpt_id = 2'd0;
    #1;
    chk("t7_still_full_a", in_ready, 0);
    tick();
    resolve_valid = 1'b0;
    #1;
    chk("t7_still_full_b", in_ready, 0);
    tick();
    chk("t7_head_retired", in_ready, 1);
    tick();
    chk("t7_reuse_slot0_valid", out_valid, 1);
    chk("t7_reuse_slot0", out_ckpt_id, 0);
    #1;
    chk("t7_count_net_ready", in_ready, 1);
    tick();
    chk("t7_slot1", out_ckpt_id, 1);
    #1;
    chk("t7_full_again", in_ready, 0);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
Name: rename_map_table

Overview:
Register-rename stage between decode and dispatch in the out-of-order RISC-V core. It consumes physical registers from free_list and translates architectural sources and destinations to physical tags. It holds branch checkpoints of the map and the free-list read pointer, and restores both on mispredict by driving the free list's re_ptr/mispredict inputs.

Parameters:
ARCH_REGS, 32, number of architectural registers (index width 5)
PREG_W, 8, physical tag width (matches free_list ptr width)
NUM_CKPT, 4, branch checkpoints, managed as an in-order ring

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low; asserted (0) clears all state immediately
in_valid  input  1  decode has an instruction
in_ready  output  1  rename accepts this cycle
rs1, rs2, rd  input  5 each  architectural indices
rd_wen  input  1  instruction writes rd
is_branch  input  1  instruction needs a checkpoint
fl_preg  input  PREG_W  physical reg at free-list head
fl_empty  input  1  free list empty
fl_ptr  input  PREG_W  current free-list read pointer
fl_read_en  output  1  pop free list this cycle (combinational)
fl_mispredict  output  1  registered copy of mispredict, to free_list.mispredict
fl_re_ptr  output  PREG_W  restore pointer, to free_list.re_ptr, valid with fl_mispredict
out_valid  output  1  renamed instruction valid
out_ready  input  1  dispatch accepts
out_prs1, out_prs2, out_prd, out_old_prd  output  PREG_W each  renamed tags; old_prd goes to the ROB for freeing at commit
out_ckpt_id  output  2  checkpoint slot (valid when out_is_branch)
out_is_branch  output  1  passthrough
mispredict  input  1  branch resolved wrong
resolve_valid  input  1  branch resolved correct
resolve_ckpt_id  input  2  slot for mispredict or resolve

Behaviour:
- Reset: map[i]=i for all i; out_valid=0; all out_* = 0; fl_mispredict=0; fl_re_ptr=0; checkpoint ring empty (head=tail=count=0).
- alloc = rd_wen && rd!=0. x0 always maps to preg 0 and is never remapped.
- in_ready = (!out_valid || out_ready) && !(alloc && fl_empty) && !(is_branch && count==NUM_CKPT) && !mispredict.
- Fire = in_valid && in_ready. fl_read_en = fire && alloc.
- Latency 1: on fire, the output register loads prs1=map[rs1] and prs2=map[rs2], both read before this instruction's own update (rs==rd reads the old mapping). It also loads prd=alloc?fl_preg:0, old_prd=alloc?map[rd]:0, and out_valid=1. The map updates map[rd]=fl_preg at the same edge, so a back-to-back dependent instruction sees the new tag.
- If no fire and out_ready, out_valid clears. Output holds stable while out_valid && !out_ready.
- Checkpoint on a fired branch:
  - Slot = tail. Save the map including this instruction's own update (JAL/JALR rd).
  - Save ptr = fl_ptr + alloc, mod 128.
  - tail++ mod NUM_CKPT, count++; out_ckpt_id = slot.
- Correct resolve: mark slot resolved. head advances over consecutive resolved slots, one per cycle, decrementing count.
- Mispredict (priority over everything):
  - The map is restored from ckpt[resolve_ckpt_id] at the edge.
  - fl_mispredict=1 for one cycle and fl_re_ptr=saved ptr.
  - tail = id+1 mod NUM_CKPT; count recomputed as (tail-head) mod NUM_CKPT, with NUM_CKPT when the ring is full; younger slots are discarded.
  - out_valid cleared (squash). No fire that cycle.
- A resolve_valid arriving in the same cycle as mispredict is ignored.
- Mispredict on a slot not currently allocated is illegal; an assertion fires.
- Simultaneous fire of a branch and a head-retire from resolve: count nets correctly (+1-1).
- Asynchronous reset mid-stream: all state returns to reset values immediately; no fl_read_en glitch after reset deasserts while in_valid is low.

Test Plan:
- After reset, rename rs1=3, rs2=0, rd=5, fl_preg=40 -> next cycle out_prs1=3, out_prs2=0, out_prd=40, out_old_prd=5; fl_read_en=1 for one cycle.
- Back-to-back: rd=5 (fl_preg=40), then rs1=5, rd=5 (fl_preg=41) -> second has prs1=40, old_prd=40, prd=41.
- rd=0 with rd_wen=1 -> fl_read_en=0, out_prd=0, map[0] stays 0.
- fl_empty=1 with alloc -> in_ready=0 and out_valid drops to 0. Same with alloc=0 -> accepted.
- Branch at fl_ptr=10 (ckpt 0), then rename x7 to 50, then mispredict id 0 -> fl_mispredict pulse, fl_re_ptr=10, map[7]=7, out_valid=0.
- Fill 4 checkpoints -> 5th branch stalls. Resolve id 1 then id 0 -> head advances by 2 and count=2. The stalled branch is accepted into slot 0.
- out_ready=0 for 3 cycles -> outputs stable, in_ready=0, no fl_read_en.
